// File: rtl/cp0_exc_if.sv
// Pipeline-to-CP0 exception and register-access bundle.
// The pipeline drives M-stage metadata and mtc0/mfc0 requests; CP0 answers.
interface cp0_exc_if;
  logic [31:0] I_pc;
  logic        I_valid;
  logic [4:0]  I_ex;
  logic        I_bd;
  logic        I_eret;
  logic [5:0]  hwint;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        we;
  logic [31:0] DOut;
  logic        O_req;
  logic [31:0] O_npc;
  logic [31:0] O_epc;
  logic        O_exl;

  modport master (
    output I_pc, I_valid, I_ex, I_bd, I_eret,
    output hwint, A1, A2, DIn, we,
    input  DOut, O_req, O_npc, O_epc, O_exl
  );

  modport slave (
    input  I_pc, I_valid, I_ex, I_bd, I_eret,
    input  hwint, A1, A2, DIn, we,
    output DOut, O_req, O_npc, O_epc, O_exl
  );
endinterface

// File: rtl/cp0_exc_unit.sv
// CP0 exception responder: interrupt/exception arbitration,
// SR/Cause/EPC state, flush request and mfc0/mtc0 access.
module cp0_exc_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VAL     = 32'h0000_0000
) (
  input logic     clk,
  input logic     reset,
  cp0_exc_if.slave bus
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic [31:0] sr;
  logic [31:0] cause;
  logic [31:0] pc_al;
  logic [31:0] epc_next;
  logic        int_pend;
  logic        exc_pend;
  logic        req;
  logic        do_eret;
  logic        do_mtc0;
  logic [31:0] dout;

  assign sr    = {16'b0, im, 8'b0, exl, ie};
  assign cause = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

  assign int_pend = ie & ~exl & (|(bus.hwint & im));
  assign exc_pend = (bus.I_ex != 5'd0) & ~exl;
  assign req      = bus.I_valid & (int_pend | exc_pend);

  assign do_eret = bus.I_valid & bus.I_eret & ~req;
  assign do_mtc0 = bus.I_valid & bus.we & ~req & ~bus.I_eret;

  // Delay-slot faults restart at the branch, one word back.
  assign pc_al    = {bus.I_pc[31:2], 2'b00};
  assign epc_next = bus.I_bd ? pc_al - 32'd4 : pc_al;

  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= bus.hwint;
      if (req) begin
        exl      <= 1'b1;
        exc_code <= int_pend ? 5'd0 : bus.I_ex;
        bd       <= bus.I_bd;
        epc      <= epc_next;
      end else if (do_eret) begin
        exl <= 1'b0;
      end else if (do_mtc0) begin
        if (bus.A2 == 5'd12) begin
          im  <= bus.DIn[15:10];
          exl <= bus.DIn[1];
          ie  <= bus.DIn[0];
        end
        if (bus.A2 == 5'd14) begin
          epc <= {bus.DIn[31:2], 2'b00};
        end
      end
    end
  end

  always_comb begin
    dout = '0;
    case (bus.A1)
      5'd12:   dout = sr;
      5'd13:   dout = cause;
      5'd14:   dout = epc;
      5'd15:   dout = PRID_VAL;
      default: dout = '0;
    endcase
  end

  assign bus.DOut  = dout;
  assign bus.O_req = req;
  assign bus.O_npc = HANDLER_ADDR;
  assign bus.O_epc = epc;
  assign bus.O_exl = exl;

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Scoreboard bench for cp0_exc_unit: directed vectors push
// expectations, a negedge monitor pops and compares them.
module tb_cp0_exc_unit;

  localparam logic [31:0] PRID = 32'h0001_9300;

  localparam int S_REQ  = 0;
  localparam int S_DOUT = 1;
  localparam int S_EPC  = 2;
  localparam int S_EXL  = 3;
  localparam int S_NPC  = 4;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   tests;
  int   fails;

  cp0_exc_if bus();

  cp0_exc_unit #(.PRID_VAL(PRID)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      act = '0;
      case (e.sel)
        S_REQ:   act = {31'b0, bus.O_req};
        S_DOUT:  act = bus.DOut;
        S_EPC:   act = bus.O_epc;
        S_EXL:   act = {31'b0, bus.O_exl};
        default: act = bus.O_npc;
      endcase
      tests++;
      if (act !== e.val) begin
        fails++;
        $display("FAIL %s: got %h want %h", e.name, act, e.val);
      end
    end
  end

  function automatic void chk(string n, int s, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = s;
    e.val  = v;
    sb.push_back(e);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.I_valid = 1'b0;
    bus.I_ex    = '0;
    bus.I_bd    = 1'b0;
    bus.I_eret  = 1'b0;
    bus.we      = 1'b0;
    bus.A2      = '0;
    bus.DIn     = '0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] v,
                    input string n);
    bus.A1 = a;
    chk(n, S_DOUT, v);
    cyc();
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.I_valid = 1'b1;
    bus.we      = 1'b1;
    bus.A2      = a;
    bus.DIn     = d;
  endtask

  task automatic eret();
    bus.I_valid = 1'b1;
    bus.I_eret  = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    bus.I_pc  = '0;
    bus.hwint = '0;
    bus.A1    = '0;
    idle();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // reset state
    chk("rst_req", S_REQ, 32'd0);
    chk("rst_exl", S_EXL, 32'd0);
    chk("rst_epc", S_EPC, 32'd0);
    rd(5'd12, 32'd0, "rst_sr");
    rd(5'd13, 32'd0, "rst_cause");
    rd(5'd14, 32'd0, "rst_epcreg");
    rd(5'd15, PRID, "prid");
    rd(5'd7, 32'd0, "rd_other");

    // interrupt
    mtc0(5'd12, 32'h0000_0401);
    chk("mtc0_sr_req", S_REQ, 32'd0);
    cyc();
    idle();
    bus.I_valid = 1'b1;
    bus.hwint   = 6'b000001;
    bus.I_pc    = 32'h3010;
    chk("int_req", S_REQ, 32'd1);
    chk("int_npc", S_NPC, 32'h4180);
    cyc();
    idle();
    chk("int_exl", S_EXL, 32'd1);
    rd(5'd12, 32'h0000_0403, "int_sr");
    rd(5'd13, 32'h0000_0400, "int_cause");
    chk("int_oepc", S_EPC, 32'h3010);
    rd(5'd14, 32'h3010, "int_epc");

    // masking while EXL=1
    bus.I_valid = 1'b1;
    bus.hwint   = 6'h3F;
    bus.I_ex    = 5'd4;
    chk("mask_req", S_REQ, 32'd0);
    cyc();
    idle();
    rd(5'd12, 32'h0000_0403, "mask_sr");
    rd(5'd13, 32'h0000_FC00, "mask_cause");
    rd(5'd14, 32'h3010, "mask_epc");

    // eret, then bubble with an interrupt pending
    eret();
    chk("eret_req", S_REQ, 32'd0);
    chk("eret_tgt", S_EPC, 32'h3010);
    cyc();
    idle();
    chk("bubble_req", S_REQ, 32'd0);
    chk("eret_exl", S_EXL, 32'd0);
    chk("eret_epc", S_EPC, 32'h3010);
    cyc();
    bus.hwint = 6'h00;
    mtc0(5'd12, 32'h0000_FC01);
    chk("mtc0_sr2_req", S_REQ, 32'd0);
    cyc();
    idle();
    bus.hwint   = 6'h20;
    bus.I_valid = 1'b1;
    bus.I_pc    = 32'h3040;
    chk("im5_req", S_REQ, 32'd1);
    cyc();
    idle();
    chk("im5_exl", S_EXL, 32'd1);
    chk("im5_oepc", S_EPC, 32'h3040);
    rd(5'd13, 32'h0000_8000, "im5_cause");

    // interrupt beats exception; concurrent mtc0 dropped
    bus.hwint = 6'h00;
    eret();
    cyc();
    idle();
    bus.hwint   = 6'h02;
    bus.I_valid = 1'b1;
    bus.I_ex    = 5'd12;
    bus.we      = 1'b1;
    bus.A2      = 5'd14;
    bus.DIn     = 32'h5000;
    bus.I_pc    = 32'h3050;
    chk("sim_req", S_REQ, 32'd1);
    cyc();
    idle();
    rd(5'd13, 32'h0000_0800, "sim_cause");
    rd(5'd14, 32'h3050, "sim_epc");

    // delay-slot exception with SR=0
    bus.hwint = 6'h00;
    eret();
    cyc();
    idle();
    mtc0(5'd12, 32'd0);
    chk("sr0_req", S_REQ, 32'd0);
    cyc();
    idle();
    bus.I_valid = 1'b1;
    bus.I_ex    = 5'd10;
    bus.I_bd    = 1'b1;
    bus.I_pc    = 32'h3024;
    chk("bd_req", S_REQ, 32'd1);
    cyc();
    idle();
    rd(5'd13, 32'h8000_0028, "bd_cause");
    rd(5'd14, 32'h3020, "bd_epc");
    rd(5'd12, 32'h0000_0002, "bd_sr");

    // EPC wrap at PC 0 in a delay slot
    eret();
    cyc();
    idle();
    bus.I_valid = 1'b1;
    bus.I_ex    = 5'd4;
    bus.I_bd    = 1'b1;
    bus.I_pc    = 32'h0;
    chk("wrap_req", S_REQ, 32'd1);
    cyc();
    idle();
    rd(5'd14, 32'hFFFF_FFFC, "wrap_epc");

    // unaligned PC gets word-aligned
    eret();
    cyc();
    idle();
    bus.I_valid = 1'b1;
    bus.I_ex    = 5'd5;
    bus.I_pc    = 32'h3027;
    chk("al_req", S_REQ, 32'd1);
    cyc();
    idle();
    rd(5'd14, 32'h3024, "al_epc");

    // register access
    mtc0(5'd14, 32'h0000_3007);
    bus.A1 = 5'd14;
    chk("wr_old", S_DOUT, 32'h3024);
    cyc();
    idle();
    chk("wr_oepc", S_EPC, 32'h3004);
    rd(5'd14, 32'h3004, "wr_new");
    mtc0(5'd13, 32'hFFFF_FFFF);
    cyc();
    idle();
    rd(5'd13, 32'h0000_0014, "cause_ro");
    mtc0(5'd15, 32'hFFFF_FFFF);
    cyc();
    idle();
    rd(5'd15, PRID, "prid_ro");
    rd(5'd7, 32'd0, "rd7");

    // reset inside handler
    mtc0(5'd14, 32'h3100);
    cyc();
    idle();
    chk("pre_exl", S_EXL, 32'd1);
    rd(5'd14, 32'h3100, "pre_epc");
    reset     = 1'b1;
    bus.hwint = 6'h3F;
    cyc();
    reset     = 1'b0;
    bus.hwint = 6'h00;
    chk("hr_exl", S_EXL, 32'd0);
    chk("hr_oepc", S_EPC, 32'd0);
    rd(5'd12, 32'd0, "hr_sr");
    rd(5'd13, 32'd0, "hr_cause");
    rd(5'd14, 32'd0, "hr_epc");

    for (int i = 0; i < 10 && sb.size() > 0; i++) cyc();
    if (sb.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
